// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the branch resolver: compare status, branch conditions, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_resolver_pkg;

  // Compare result held in status[1:0]. ST_NONE means no compare has happened since reset.
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_LT   = 2'b01;
  localparam logic [1:0] ST_GT   = 2'b11;
  localparam logic [1:0] ST_EQ   = 2'b10;

  // Branch condition codes
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b010;
  localparam logic [2:0] BR_BGT  = 3'b011;
  localparam logic [2:0] BR_BLE  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_JMP  = 3'b110;
  localparam logic [2:0] BR_RSVD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_SR = 2'd1,
    S_FLUSH   = 2'd2
  } br_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch predicate: decides taken from a condition code and the 2-bit compare status.
// Latency: combinational.
// Backpressure: none.
// Ports: cond (condition code), status (compare result), taken (predicate result).
module branch_cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [1:0] status,
  output logic       taken
);

  logic is_lt;
  logic is_gt;
  logic is_eq;

  // ST_NONE leaves all three flags clear, so every conditional branch falls through.
  assign is_lt = (status == ST_LT);
  assign is_gt = (status == ST_GT);
  assign is_eq = (status == ST_EQ);

  always_comb begin
    taken = 1'b0;
    case (cond)
      BR_BEQ:  taken = is_eq;
      BR_BNE:  taken = is_lt | is_gt;
      BR_BLT:  taken = is_lt;
      BR_BGT:  taken = is_gt;
      BR_BLE:  taken = is_lt | is_eq;
      BR_BGE:  taken = is_gt | is_eq;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves branches against the status register; emits next PC, redirect pulse and flush window.
// Latency: accept to pc_next_valid is 1 cycle, or 2 cycles when SRw is high at accept.
// Backpressure: br_ready low while waiting for the status write to land and during the flush window.
// Ports: CLK/reset; br_valid/br_ready request handshake with br_cond, br_target, pc_in;
//        status_in/SRw from the status register; pc_next/pc_next_valid/taken result;
//        stall, flush pipeline controls; taken_count saturating statistic.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int STATUS_W     = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                br_valid,
  input  logic [2:0]          br_cond,
  input  logic [PC_W-1:0]     br_target,
  input  logic [PC_W-1:0]     pc_in,
  input  logic [STATUS_W-1:0] status_in,
  input  logic                SRw,
  output logic                br_ready,
  output logic                stall,
  output logic [PC_W-1:0]     pc_next,
  output logic                pc_next_valid,
  output logic                taken,
  output logic                flush,
  output logic [15:0]         taken_count
);

  localparam bit HAS_FLUSH = (FLUSH_CYCLES > 0);
  localparam int FW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  // Counter runs FLUSH_CYCLES-1 down to 0, one FLUSH cycle per value.
  localparam logic [FW-1:0] FLUSH_LOAD = FW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  br_state_t       state;
  br_state_t       state_nxt;
  logic [FW-1:0]   flush_cnt;

  logic [2:0]      lat_cond;
  logic [PC_W-1:0] lat_target;
  logic [PC_W-1:0] lat_pc;

  logic            accept;
  logic            resolve;
  logic [2:0]      sel_cond;
  logic [PC_W-1:0] sel_target;
  logic [PC_W-1:0] sel_pc;
  logic            res_taken;

  assign accept = br_valid & br_ready;

  // Resolve directly on a clean accept; after a status write, resolve one cycle later
  // from the latched request once status_in carries the new value.
  assign resolve    = (state == S_IDLE && accept && !SRw) || (state == S_WAIT_SR);
  assign sel_cond   = (state == S_WAIT_SR) ? lat_cond   : br_cond;
  assign sel_target = (state == S_WAIT_SR) ? lat_target : br_target;
  assign sel_pc     = (state == S_WAIT_SR) ? lat_pc     : pc_in;

  branch_cond_eval u_cond_eval (
    .cond   (sel_cond),
    .status (status_in[1:0]),
    .taken  (res_taken)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (SRw)                         state_nxt = S_WAIT_SR;
          else if (res_taken && HAS_FLUSH) state_nxt = S_FLUSH;
        end
      end
      S_WAIT_SR: state_nxt = (res_taken && HAS_FLUSH) ? S_FLUSH : S_IDLE;
      S_FLUSH:   if (flush_cnt == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    br_ready = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    case (state)
      S_IDLE:    br_ready = 1'b1;
      S_WAIT_SR: stall    = 1'b1;
      S_FLUSH:   flush    = 1'b1;
      default:   br_ready = 1'b0;
    endcase
  end

  // Request latch, registered result, flush counter, statistics
  always_ff @(posedge CLK) begin
    if (reset) begin
      lat_cond      <= '0;
      lat_target    <= '0;
      lat_pc        <= '0;
      pc_next       <= '0;
      pc_next_valid <= 1'b0;
      taken         <= 1'b0;
      taken_count   <= '0;
      flush_cnt     <= '0;
    end else begin
      pc_next_valid <= resolve;
      taken         <= resolve & res_taken;
      if (accept) begin
        lat_cond   <= br_cond;
        lat_target <= br_target;
        lat_pc     <= pc_in;
      end
      if (resolve) begin
        pc_next <= res_taken ? sel_target : sel_pc + PC_W'(1);
        if (res_taken && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
      end
      if (resolve && res_taken)                      flush_cnt <= FLUSH_LOAD;
      else if (state == S_FLUSH && flush_cnt != '0)  flush_cnt <= flush_cnt - FW'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: main instance with FLUSH_CYCLES=2, second with 0 for saturation.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  logic        CLK = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic [15:0] pc_in;
  logic [15:0] status_in;
  logic        SRw;
  logic        br_ready, stall, pc_next_valid, taken, flush;
  logic [15:0] pc_next, taken_count;

  logic        s_valid;
  logic        s_ready, s_stall, s_pcv, s_taken, s_flush;
  logic [15:0] s_pc_next, s_count;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  branch_resolver #(.PC_W(16), .STATUS_W(16), .FLUSH_CYCLES(2)) u_dut (
    .CLK(CLK), .reset(reset), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .pc_in(pc_in), .status_in(status_in), .SRw(SRw),
    .br_ready(br_ready), .stall(stall), .pc_next(pc_next), .pc_next_valid(pc_next_valid),
    .taken(taken), .flush(flush), .taken_count(taken_count)
  );

  branch_resolver #(.PC_W(16), .STATUS_W(16), .FLUSH_CYCLES(0)) u_sat (
    .CLK(CLK), .reset(reset), .br_valid(s_valid), .br_cond(BR_JMP),
    .br_target(16'h1234), .pc_in(16'h0100), .status_in(16'h0000), .SRw(1'b0),
    .br_ready(s_ready), .stall(s_stall), .pc_next(s_pc_next), .pc_next_valid(s_pcv),
    .taken(s_taken), .flush(s_flush), .taken_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic present(input logic [2:0] c, input logic [15:0] pc, input logic [15:0] tgt,
                         input logic [1:0] st, input logic srw);
    br_valid  = 1'b1;
    br_cond   = c;
    pc_in     = pc;
    br_target = tgt;
    status_in = {14'h1A5, st};  // upper bits are junk and must be ignored
    SRw       = srw;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    br_valid = 1'b0;
    SRw      = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; br_valid = 1'b0; br_cond = '0; br_target = '0; pc_in = '0;
    status_in = '0; SRw = 1'b0; s_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready", br_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_pcv",   pc_next_valid, 0);
    chk("rst_pc",    pc_next, 16'h0000);
    chk("rst_cnt",   taken_count, 0);

    // 1: BEQ with EQ -> taken, then 2-cycle flush
    present(BR_BEQ, 16'h0010, 16'h0040, ST_EQ, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("t1_pcv",   pc_next_valid, 1);
    chk("t1_taken", taken, 1);
    chk("t1_pc",    pc_next, 16'h0040);
    chk("t1_flush1", flush, 1);
    chk("t1_rdy1",  br_ready, 0);
    chk("t1_cnt",   taken_count, 1);
    tick();
    chk("t1_flush2", flush, 1);
    chk("t1_pcv_off", pc_next_valid, 0);
    tick();
    chk("t1_flush_end", flush, 0);
    chk("t1_rdy_back", br_ready, 1);

    // 2: BLT with GT -> not taken, back-to-back with BEQ with GT
    present(BR_BLT, 16'h0020, 16'h0099, ST_GT, 1'b0);
    tick();
    chk("t2_pcv",   pc_next_valid, 1);
    chk("t2_taken", taken, 0);
    chk("t2_pc",    pc_next, 16'h0021);
    chk("t2_rdy",   br_ready, 1);
    chk("t2_flush", flush, 0);
    present(BR_BEQ, 16'h0030, 16'h0077, ST_GT, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("t2b_pcv", pc_next_valid, 1);
    chk("t2b_pc",  pc_next, 16'h0031);
    tick();
    chk("t2_hold_pcv", pc_next_valid, 0);
    chk("t2_hold_pc",  pc_next, 16'h0031);

    // 3: hazard, BGT while status is being written LT -> GT
    present(BR_BGT, 16'h0050, 16'h0080, ST_LT, 1'b1);
    tick();
    br_valid = 1'b0; SRw = 1'b0; status_in = {14'h0, ST_GT};
    chk("t3_stall", stall, 1);
    chk("t3_rdy",   br_ready, 0);
    chk("t3_pcv0",  pc_next_valid, 0);
    tick();
    chk("t3_stall_off", stall, 0);
    chk("t3_pcv",   pc_next_valid, 1);
    chk("t3_taken", taken, 1);
    chk("t3_pc",    pc_next, 16'h0080);
    chk("t3_cnt",   taken_count, 2);
    tick(); tick();
    chk("t3_rdy_back", br_ready, 1);

    // 4: status NONE after reset
    do_reset();
    chk("t4_cnt_rst", taken_count, 0);
    present(BR_BGE, 16'h0200, 16'h0300, ST_NONE, 1'b0);
    tick();
    chk("t4_bge", taken, 0);
    chk("t4_bge_pcv", pc_next_valid, 1);
    present(BR_BNE, 16'h0201, 16'h0300, ST_NONE, 1'b0);
    tick();
    chk("t4_bne", taken, 0);
    present(BR_BLE, 16'h0202, 16'h0300, ST_NONE, 1'b0);
    tick();
    chk("t4_ble", taken, 0);
    chk("t4_ble_pc", pc_next, 16'h0203);
    present(BR_JMP, 16'h0203, 16'h0300, ST_NONE, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("t4_jmp", taken, 1);
    chk("t4_jmp_pc", pc_next, 16'h0300);
    tick(); tick();
    present(BR_RSVD, 16'h0100, 16'h0500, ST_EQ, 1'b0);
    tick();
    chk("t4_rsvd", taken, 0);
    chk("t4_rsvd_pc", pc_next, 16'h0101);

    // 5a: PC wrap on not-taken
    present(BR_BEQ, 16'hFFFF, 16'h0500, ST_LT, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("t5_wrap", pc_next, 16'h0000);
    chk("t5_wrap_taken", taken, 0);

    // 6a: reset during WAIT_SR
    present(BR_BLT, 16'h0600, 16'h0700, ST_EQ, 1'b1);
    tick();
    chk("t6_in_wait", stall, 1);
    do_reset();
    chk("t6a_stall", stall, 0);
    chk("t6a_rdy",   br_ready, 1);
    chk("t6a_flush", flush, 0);
    chk("t6a_pcv",   pc_next_valid, 0);
    chk("t6a_cnt",   taken_count, 0);
    chk("t6a_pc",    pc_next, 16'h0000);

    // 6b: reset during FLUSH cycle 1
    present(BR_JMP, 16'h0610, 16'h0800, ST_NONE, 1'b0);
    tick();
    br_valid = 1'b0;
    chk("t6_in_flush", flush, 1);
    chk("t6_cnt_pre", taken_count, 1);
    do_reset();
    chk("t6b_flush", flush, 0);
    chk("t6b_stall", stall, 0);
    chk("t6b_rdy",   br_ready, 1);
    chk("t6b_pcv",   pc_next_valid, 0);
    chk("t6b_cnt",   taken_count, 0);

    // 5b: saturation on the flush-less instance, one JMP accepted per cycle
    s_valid = 1'b1;
    repeat (65534) tick();
    chk("t5_cnt_fffe", s_count, 16'hFFFE);
    chk("t5_no_flush", s_flush, 0);
    tick();
    chk("t5_cnt_ffff", s_count, 16'hFFFF);
    tick();
    chk("t5_sat", s_count, 16'hFFFF);
    chk("t5_sat_taken", s_taken, 1);
    chk("t5_sat_pc", s_pc_next, 16'h1234);
    s_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
